// File: rtl/multiway_traffic_controller.sv
// multiway_traffic_controller: N-way round-robin intersection controller with min/max green, extension, rest-on-main and preemption
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   sensor[N_WAY]   vehicle present per approach
//   preempt         emergency preemption request (level)
//   preempt_id      approach to preempt to
//   light[3*N_WAY]  {red, yellow, green} per approach
//   cur_way         approach owning the green/yellow phase
//   phase           0=GREEN, 1=YELLOW, 2=ALL_RED
module multiway_traffic_controller #(
    parameter int N_WAY         = 4,
    parameter int TICKS_PER_SEC = 50,
    parameter int GREEN_MIN     = 10,
    parameter int GREEN_MAX     = 30,
    parameter int YELLOW_T      = 3,
    parameter int ALL_RED_T     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_WAY-1:0]           sensor,
    input  logic                       preempt,
    input  logic [$clog2(N_WAY)-1:0]   preempt_id,
    output logic [3*N_WAY-1:0]         light,
    output logic [$clog2(N_WAY)-1:0]   cur_way,
    output logic [1:0]                 phase
);
    localparam int WW   = $clog2(N_WAY);
    localparam int TMAX = (GREEN_MAX > YELLOW_T) ? ((GREEN_MAX > ALL_RED_T) ? GREEN_MAX : ALL_RED_T)
                                                 : ((YELLOW_T > ALL_RED_T) ? YELLOW_T : ALL_RED_T);
    localparam int SW   = $clog2(TMAX + 2);
    localparam int PW   = $clog2(TICKS_PER_SEC + 1);

    typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALL_RED = 2'd2} phase_t;

    phase_t            state, state_n;
    logic [N_WAY-1:0]  demand, demand_n, dmd, cur_mask, gmask;
    logic [PW-1:0]     presc;
    logic [SW-1:0]     secs, el;
    logic [WW-1:0]     rr, nxt;
    logic              tick, other, found, go_y, enter_green;

    assign phase = state;

    always_comb begin
        cur_mask = '0;
        cur_mask[cur_way] = 1'b1;
        gmask = (state == GREEN) ? cur_mask : '0;
        // Live sensors count as demand this cycle so a request exits on the very next edge
        dmd   = demand | (sensor & ~gmask);
        other = |(dmd & ~cur_mask);
        tick  = presc == PW'(TICKS_PER_SEC - 1);
        // Seconds elapsed once the current cycle completes; timed exits fire on that edge
        el    = secs + SW'(tick);
        rr    = '0;
        found = 1'b0;
        for (int k = 1; k < N_WAY; k++) begin
            if (!found && dmd[(int'(cur_way) + k) % N_WAY]) begin
                rr    = WW'((int'(cur_way) + k) % N_WAY);
                found = 1'b1;
            end
        end
        nxt  = preempt ? preempt_id : (found ? rr : '0);
        go_y = preempt ? (preempt_id != cur_way)
                       : ((el >= SW'(GREEN_MAX) && other) ||
                          (el >= SW'(GREEN_MIN) && other && !sensor[cur_way]) ||
                          (el >= SW'(GREEN_MIN) && cur_way != '0 && dmd == '0));
        state_n = (state == GREEN)  ? (go_y ? YELLOW : GREEN) :
                  (state == YELLOW) ? ((el >= SW'(YELLOW_T)) ? ALL_RED : YELLOW) :
                                      ((el >= SW'(ALL_RED_T)) ? GREEN : ALL_RED);
        enter_green = (state == ALL_RED) && (state_n == GREEN);
        demand_n = dmd;
        if (enter_green) demand_n[nxt] = 1'b0;
        light = {N_WAY{3'b100}};
        light[3*cur_way +: 3] = (state == GREEN) ? 3'b001 : (state == YELLOW) ? 3'b010 : 3'b100;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= GREEN;
            cur_way <= '0;
            demand  <= '0;
            presc   <= '0;
            secs    <= '0;
        end else begin
            state  <= state_n;
            demand <= demand_n;
            if (enter_green) cur_way <= nxt;
            if (state_n != state) begin
                presc <= '0;
                secs  <= '0;
            end else begin
                presc <= tick ? '0 : presc + 1'b1;
                secs  <= (tick && secs < SW'(TMAX)) ? secs + 1'b1 : secs;
            end
        end
    end
endmodule

// File: doc/multiway_traffic_controller.md
# multiway_traffic_controller

Parametrised N-way intersection controller, successor to the two-road highway/country controller. Serves N_WAY approaches round-robin on latched vehicle demand, with minimum and maximum green, sensor-driven green extension, rest-on-main, and single-approach emergency preemption. All phase timing is in seconds derived from the system clock by an internal prescaler. Its light outputs drive the signal-head drivers directly.

## Interface
- N_WAY, 4: number of approaches, 2..8; approach 0 is the main road.
- TICKS_PER_SEC, 50: clk cycles per second (50 Hz system clock).
- GREEN_MIN, 10: minimum green, seconds (>=1).
- GREEN_MAX, 30: maximum green while another approach waits, seconds (>GREEN_MIN).
- YELLOW_T, 3: yellow duration, seconds (>=1).
- ALL_RED_T, 1: all-red clearance, seconds (>=1).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- sensor  in  N_WAY  vehicle present, one bit per approach, synchronous to clk.
- preempt  in  1  emergency preemption request, level.
- preempt_id  in  $clog2(N_WAY)  approach to preempt to; sampled while preempt=1.
- light  out  3*N_WAY  light[3i+2:3i] = {red, yellow, green} for approach i.
- cur_way  out  $clog2(N_WAY)  approach currently owning the green/yellow phase.
- phase  out  2  0=GREEN, 1=YELLOW, 2=ALL_RED.

## Operation
- Reset values: phase=GREEN, cur_way=0, demand=0, timers=0; light: approach 0 = 001, all others = 100.
- Lights: GREEN → cur_way 001, others 100; YELLOW → cur_way 010, others 100; ALL_RED → all 100. Never two non-red approaches.
- Demand: demand[i] set on any cycle sensor[i]=1, except while i is in GREEN. demand[i] cleared on entry to GREEN of i (clear wins).
- other_demand = any demand[j], j != cur_way.
- GREEN exit (to YELLOW), first match:
  - preempt=1 and preempt_id != cur_way: immediately, ignoring GREEN_MIN.
  - preempt=1 and preempt_id == cur_way: hold GREEN; no other exit.
  - elapsed >= GREEN_MAX and other_demand.
  - elapsed >= GREEN_MIN, other_demand, sensor[cur_way]=0.
  - elapsed >= GREEN_MIN, cur_way != 0, no demand anywhere (return to main).
  - Otherwise stay; approach 0 rests green indefinitely with no demand.
- YELLOW lasts YELLOW_T s, then ALL_RED lasts ALL_RED_T s; neither is shortened by preemption.
- Next approach, chosen on ALL_RED exit: preempt=1 → preempt_id; else first demanded index cyclically after cur_way; else 0.
- Preemption to the approach already in YELLOW/ALL_RED completes clearance and then re-greens that approach.

## Timing
- Prescaler counts 0..TICKS_PER_SEC-1. It and the seconds counter (elapsed) clear on every phase entry, so a phase of S seconds is exactly S*TICKS_PER_SEC cycles.
- Timed exits take effect on the edge completing the last cycle. Demand/preempt exits take effect on the first edge where the condition holds (one-cycle latency from input).
- Seconds counter saturates at GREEN_MAX; no wrap.
- rst mid-phase: outputs return to reset values asynchronously, with no yellow/all-red sequence.
- Sensor pulses of one cycle are captured.

## Test plan
Use N_WAY=4, TICKS_PER_SEC=2, GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALL_RED_T=1. Cycle counts are from rst release.
- Reset/rest: rst high, release, no sensors for 200 cycles → light=12'b100_100_100_001 throughout; phase=0, cur_way=0.
- Single request: 1-cycle sensor[2] pulse at cycle 20:
  - cycle 21: way0 = 010 for 4 cycles.
  - Then all 100 for 2 cycles.
  - Then way2 = 001 for 8 cycles, yellow 4, all-red 2.
  - Then way0 green.
- Extension and max: way1 green with sensor[1] held high and demand[3] set → way1 green exactly 16 cycles, then yellow; sensor[1] low → green exactly 8 cycles.
- Round-robin: sensor[3:1]=3'b111 for 1 cycle while way0 rests green → green order 1, 2, 3, then 0; each non-main green lasts 8 cycles.
- Preemption: way1 green for 2 cycles, preempt=1 with preempt_id=3:
  - Next edge: way1 yellow.
  - After yellow and all-red: way3 green, held 50+ cycles while preempt=1.
  - Drop preempt → way3 exits after normal rules.
- Async reset: rst pulsed mid-YELLOW between clock edges → light=12'b100_100_100_001 before the next clk edge, demand cleared.
